// File: rtl/core_pkg.sv
// Shared decode definitions: immediate-format select codes (also used by the
// control unit) and the datapath-width legality check.
package core_pkg;

  localparam logic [2:0] IMM_I   = 3'b000;
  localparam logic [2:0] IMM_S   = 3'b001;
  localparam logic [2:0] IMM_B   = 3'b010;
  localparam logic [2:0] IMM_U   = 3'b011;
  localparam logic [2:0] IMM_J   = 3'b100;
  localparam logic [2:0] IMM_Z   = 3'b101;
  localparam logic [2:0] IMM_SH  = 3'b110;
  localparam logic [2:0] IMM_ILL = 3'b111;

  // Only RV32 and RV64 datapaths are supported.
  function automatic bit xlen_legal(input int unsigned xlen);
    return (xlen == 32) || (xlen == 64);
  endfunction

endpackage

// File: rtl/imm_format_xlen.sv
// Combinational immediate extractor.
// Ports: inst  - 32-bit instruction word
//        src   - immediate format select (core_pkg IMM_*)
//        imm   - immediate extended to XLEN
//        err   - format select is the illegal code
module imm_format_xlen
  import core_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [31:0]     inst,
  input  logic [2:0]      src,
  output logic [XLEN-1:0] imm,
  output logic            err
);

  // Shift amounts are 6 bits wide on RV64, 5 bits on RV32.
  localparam int unsigned SH_W = (XLEN == 64) ? 6 : 5;

  // Opcode bits never contribute to an immediate.
  logic w_unused_opcode;
  assign w_unused_opcode = ^inst[6:0];

  // Field extraction; signed casts perform the sign extension to XLEN.
  always_comb begin
    imm = '0;
    err = 1'b0;
    case (src)
      IMM_I:   imm = XLEN'($signed(inst[31:20]));
      IMM_S:   imm = XLEN'($signed({inst[31:25], inst[11:7]}));
      IMM_B:   imm = XLEN'($signed({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}));
      IMM_U:   imm = XLEN'($signed({inst[31:12], 12'b0}));
      IMM_J:   imm = XLEN'($signed({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}));
      IMM_Z:   imm = XLEN'(inst[19:15]);
      IMM_SH:  imm = XLEN'(inst[20 +: SH_W]);
      default: begin
        imm = '0;
        err = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/imm_decode_stage.sv
// Registered immediate-generation stage with valid/ready handshake and an
// optional 2-entry skid buffer.
// Ports: clk, rst_n (async active-low), flush (sync)
//        in_valid/in_ready, in_inst, in_pc, in_imm_src, in_tag  - input side
//        out_valid/out_ready, out_imm, out_target, out_tag, out_err - output side
module imm_decode_stage
  import core_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned TAG_W = 8,
  parameter int unsigned SKID  = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_inst,
  input  logic [XLEN-1:0]  in_pc,
  input  logic [2:0]       in_imm_src,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [XLEN-1:0]  out_target,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_err
);

  localparam int unsigned PAY_W = 2 * XLEN + TAG_W + 1;

  if (!xlen_legal(XLEN)) begin : g_bad_xlen
    $error("imm_decode_stage: XLEN must be 32 or 64");
  end

  logic [XLEN-1:0]  w_imm;
  logic             w_err;
  logic [XLEN-1:0]  w_target;
  logic [PAY_W-1:0] w_pay;
  logic             w_in_fire;
  logic             w_drain;

  logic             r_main_v;
  logic [PAY_W-1:0] r_main_pay;

  imm_format_xlen #(.XLEN(XLEN)) u_fmt (
    .inst (in_inst),
    .src  (in_imm_src),
    .imm  (w_imm),
    .err  (w_err)
  );

  // Illegal format yields imm=0, so the target collapses to the PC.
  assign w_target  = in_pc + w_imm;
  assign w_pay     = {w_err, in_tag, w_target, w_imm};
  assign w_in_fire = in_valid & in_ready & ~flush;
  // Main register is free to take new contents this cycle.
  assign w_drain   = ~r_main_v | out_ready;

  if (SKID != 0) begin : g_skid
    logic             r_skid_v;
    logic [PAY_W-1:0] r_skid_pay;

    assign in_ready = ~r_skid_v;

    // Skid refills main first; inputs only land in skid while main stalls.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_main_v   <= 1'b0;
        r_skid_v   <= 1'b0;
        r_main_pay <= '0;
        r_skid_pay <= '0;
      end else if (flush) begin
        r_main_v <= 1'b0;
        r_skid_v <= 1'b0;
      end else if (w_drain) begin
        if (r_skid_v) begin
          r_main_v   <= 1'b1;
          r_main_pay <= r_skid_pay;
          r_skid_v   <= 1'b0;
        end else begin
          r_main_v <= w_in_fire;
          if (w_in_fire) r_main_pay <= w_pay;
        end
      end else if (w_in_fire) begin
        r_skid_v   <= 1'b1;
        r_skid_pay <= w_pay;
      end
    end
  end else begin : g_noskid
    assign in_ready = w_drain;

    // Single output register.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_main_v   <= 1'b0;
        r_main_pay <= '0;
      end else if (flush) begin
        r_main_v <= 1'b0;
      end else if (w_drain) begin
        r_main_v <= w_in_fire;
        if (w_in_fire) r_main_pay <= w_pay;
      end
    end
  end

  assign out_valid = r_main_v;
  assign {out_err, out_tag, out_target, out_imm} = r_main_pay;

endmodule

// File: tb/tb_imm_decode_stage.sv
// Bench for imm_decode_stage: a 32-bit skid-buffered instance and a 64-bit
// single-register instance share the input stimulus; each is tracked by its
// own transaction queue of expected results.
module tb_imm_decode_stage;

  typedef struct packed {
    logic [63:0] imm;
    logic [63:0] tgt;
    logic [7:0]  tag;
    logic        err;
  } exp_t;

  typedef struct packed {
    logic [2:0]  src;
    logic [31:0] inst;
    logic [63:0] pc;
    logic [31:0] imm32;
    logic [31:0] tgt32;
    logic [63:0] imm64;
    logic [63:0] tgt64;
    logic        err;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic [31:0] in_inst;
  logic [63:0] in_pc;
  logic [2:0]  in_imm_src;
  logic [7:0]  in_tag;
  logic        out_ready;

  logic        a_in_ready, a_out_valid, a_err;
  logic [31:0] a_imm, a_tgt;
  logic [7:0]  a_tag;
  logic        b_in_ready, b_out_valid, b_err;
  logic [63:0] b_imm, b_tgt;
  logic [7:0]  b_tag;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   acc_a    = 0;
  exp_t qa[$];
  exp_t qb[$];
  logic [7:0] seen_a[$];

  always #5 clk = ~clk;

  imm_decode_stage #(.XLEN(32), .TAG_W(8), .SKID(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(a_in_ready), .in_inst(in_inst),
    .in_pc(in_pc[31:0]), .in_imm_src(in_imm_src), .in_tag(in_tag),
    .out_valid(a_out_valid), .out_ready(out_ready), .out_imm(a_imm),
    .out_target(a_tgt), .out_tag(a_tag), .out_err(a_err)
  );

  imm_decode_stage #(.XLEN(64), .TAG_W(8), .SKID(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(b_in_ready), .in_inst(in_inst),
    .in_pc(in_pc), .in_imm_src(in_imm_src), .in_tag(in_tag),
    .out_valid(b_out_valid), .out_ready(out_ready), .out_imm(b_imm),
    .out_target(b_tgt), .out_tag(b_tag), .out_err(b_err)
  );

  // Immediate value as a plain signed integer, then truncated to the width.
  function automatic exp_t model_xact(input logic [31:0] inst, input logic [2:0] src,
                                      input logic [63:0] pc, input logic [7:0] tag,
                                      input int xlen);
    longint      v;
    logic [63:0] mask;
    exp_t        e;
    case (src)
      3'd0: v = longint'($signed(inst[31:20]));
      3'd1: v = longint'($signed({inst[31:25], inst[11:7]}));
      3'd2: v = longint'($signed({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}));
      3'd3: v = longint'($signed(inst[31:12])) * 4096;
      3'd4: v = longint'($signed({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}));
      3'd5: v = longint'(inst[19:15]);
      3'd6: v = (xlen == 64) ? longint'(inst[25:20]) : longint'(inst[24:20]);
      default: v = 0;
    endcase
    mask  = (xlen == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
    e.imm = 64'(v) & mask;
    e.tgt = (pc + 64'(v)) & mask;
    e.tag = tag;
    e.err = (src == 3'd7);
    return e;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Transaction bookkeeping on each edge, using pre-edge values.
  always @(posedge clk) begin
    if (rst_n) begin
      if (a_out_valid && out_ready && qa.size() > 0) begin
        seen_a.push_back(a_tag);
        void'(qa.pop_front());
      end
      if (b_out_valid && out_ready && qb.size() > 0) void'(qb.pop_front());
      if (flush) begin
        qa.delete();
        qb.delete();
      end else if (in_valid) begin
        if (a_in_ready) begin
          qa.push_back(model_xact(in_inst, in_imm_src, in_pc, in_tag, 32));
          acc_a++;
        end
        if (b_in_ready) qb.push_back(model_xact(in_inst, in_imm_src, in_pc, in_tag, 64));
      end
    end
  end

  // Per-cycle comparison of both instances against their queues.
  task automatic check_cycle();
    chk("a_valid", 64'(a_out_valid), 64'(qa.size() > 0));
    chk("a_in_ready", 64'(a_in_ready), 64'(qa.size() < 2));
    if (qa.size() > 0 && a_out_valid) begin
      chk("a_imm", 64'(a_imm), qa[0].imm);
      chk("a_target", 64'(a_tgt), qa[0].tgt);
      chk("a_tag", 64'(a_tag), 64'(qa[0].tag));
      chk("a_err", 64'(a_err), 64'(qa[0].err));
    end
    chk("b_valid", 64'(b_out_valid), 64'(qb.size() > 0));
    chk("b_in_ready", 64'(b_in_ready), 64'(qb.size() == 0 || out_ready));
    if (qb.size() > 0 && b_out_valid) begin
      chk("b_imm", b_imm, qb[0].imm);
      chk("b_target", b_tgt, qb[0].tgt);
      chk("b_tag", 64'(b_tag), 64'(qb[0].tag));
      chk("b_err", 64'(b_err), 64'(qb[0].err));
    end
  endtask

  task automatic drive(input logic [7:0] tag);
    in_valid   = 1'b1;
    in_inst    = $urandom;
    in_imm_src = 3'($urandom_range(0, 6));
    in_pc      = {$urandom, $urandom};
    in_tag     = tag;
  endtask

  task automatic check_reset_values(input string where);
    chk({where, "_a_valid"}, 64'(a_out_valid), 64'd0);
    chk({where, "_a_imm"}, 64'(a_imm), 64'd0);
    chk({where, "_a_target"}, 64'(a_tgt), 64'd0);
    chk({where, "_a_tag"}, 64'(a_tag), 64'd0);
    chk({where, "_a_err"}, 64'(a_err), 64'd0);
    chk({where, "_a_in_ready"}, 64'(a_in_ready), 64'd1);
    chk({where, "_b_valid"}, 64'(b_out_valid), 64'd0);
    chk({where, "_b_imm"}, b_imm, 64'd0);
    chk({where, "_b_target"}, b_tgt, 64'd0);
    chk({where, "_b_err"}, 64'(b_err), 64'd0);
  endtask

  initial begin
    vec_t        vecs[8];
    logic [31:0] snap_imm;
    int          acc0;

    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_inst = '0;
    in_pc = '0; in_imm_src = '0; in_tag = '0; out_ready = 1'b1;

    vecs[0] = '{3'd0, 32'hFFF00093, 64'h0,    32'hFFFFFFFF, 32'hFFFFFFFF,
                64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 1'b0};
    vecs[1] = '{3'd2, 32'hFE000EE3, 64'h100,  32'hFFFFFFFC, 32'h000000FC,
                64'hFFFFFFFFFFFFFFFC, 64'h00000000000000FC, 1'b0};
    vecs[2] = '{3'd4, 32'h008000EF, 64'h1000, 32'h00000008, 32'h00001008,
                64'h8, 64'h1008, 1'b0};
    vecs[3] = '{3'd3, 32'h800000B7, 64'h0,    32'h80000000, 32'h80000000,
                64'hFFFFFFFF80000000, 64'hFFFFFFFF80000000, 1'b0};
    vecs[4] = '{3'd5, 32'h000F8000, 64'h20,   32'h1F, 32'h3F, 64'h1F, 64'h3F, 1'b0};
    vecs[5] = '{3'd7, 32'hFFFFFFFF, 64'h1234, 32'h0, 32'h1234, 64'h0, 64'h1234, 1'b1};
    vecs[6] = '{3'd6, 32'h03F00013, 64'h0,    32'h1F, 32'h1F, 64'h3F, 64'h3F, 1'b0};
    vecs[7] = '{3'd1, 32'hFE000FA3, 64'h10,   32'hFFFFFFFF, 32'h0000000F,
                64'hFFFFFFFFFFFFFFFF, 64'h000000000000000F, 1'b0};

    repeat (2) @(negedge clk);
    check_reset_values("reset");
    rst_n = 1'b1;

    // Directed vectors, back to back with the output always ready.
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; in_inst = vecs[i].inst; in_imm_src = vecs[i].src;
      in_pc = vecs[i].pc; in_tag = 8'(i + 1);
      @(negedge clk);
      chk($sformatf("vec%0d_a_valid", i), 64'(a_out_valid), 64'd1);
      chk($sformatf("vec%0d_a_imm", i), 64'(a_imm), 64'(vecs[i].imm32));
      chk($sformatf("vec%0d_a_target", i), 64'(a_tgt), 64'(vecs[i].tgt32));
      chk($sformatf("vec%0d_a_err", i), 64'(a_err), 64'(vecs[i].err));
      chk($sformatf("vec%0d_a_tag", i), 64'(a_tag), 64'(i + 1));
      chk($sformatf("vec%0d_b_imm", i), b_imm, vecs[i].imm64);
      chk($sformatf("vec%0d_b_target", i), b_tgt, vecs[i].tgt64);
      chk($sformatf("vec%0d_b_err", i), 64'(b_err), 64'(vecs[i].err));
      check_cycle();
    end
    in_valid = 1'b0;
    @(negedge clk); check_cycle();

    // Stall with three offers: two accepted, third held off.
    out_ready = 1'b0;
    acc0 = acc_a;
    seen_a.delete();
    drive(8'hA1);
    @(negedge clk); check_cycle();
    snap_imm = a_imm;
    drive(8'hA2);
    @(negedge clk); check_cycle();
    drive(8'hA3);
    @(negedge clk); check_cycle();
    @(negedge clk); check_cycle();
    chk("stall_accepted", 64'(acc_a - acc0), 64'd2);
    chk("stall_in_ready", 64'(a_in_ready), 64'd0);
    chk("stall_tag_stable", 64'(a_tag), 64'hA1);
    chk("stall_imm_stable", 64'(a_imm), 64'(snap_imm));
    out_ready = 1'b1;
    for (int i = 0; i < 10 && (acc_a - acc0) < 3; i++) begin
      @(negedge clk); check_cycle();
    end
    in_valid = 1'b0;
    for (int i = 0; i < 10 && (qa.size() > 0 || qb.size() > 0); i++) begin
      @(negedge clk); check_cycle();
    end
    chk("release_count", 64'(seen_a.size()), 64'd3);
    if (seen_a.size() == 3) begin
      chk("release_tag0", 64'(seen_a[0]), 64'hA1);
      chk("release_tag1", 64'(seen_a[1]), 64'hA2);
      chk("release_tag2", 64'(seen_a[2]), 64'hA3);
    end

    // Flush with two held entries and an input offered in the flush cycle.
    out_ready = 1'b0;
    drive(8'hB1);
    @(negedge clk); check_cycle();
    drive(8'hB2);
    @(negedge clk); check_cycle();
    in_valid = 1'b0;
    chk("preflush_full", 64'(a_in_ready), 64'd0);
    flush = 1'b1;
    drive(8'hB3);
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_a_valid", 64'(a_out_valid), 64'd0);
    chk("flush_a_in_ready", 64'(a_in_ready), 64'd1);
    chk("flush_b_valid", 64'(b_out_valid), 64'd0);
    check_cycle();

    // Asynchronous reset in the middle of a stall.
    drive(8'hC1);
    @(negedge clk); check_cycle();
    drive(8'hC2);
    @(negedge clk); check_cycle();
    #2 rst_n = 1'b0;
    qa.delete(); qb.delete();
    #1 check_reset_values("midreset");
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk); check_cycle();

    // Randomized traffic with occasional flushes.
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      check_cycle();
      in_valid   = ($urandom % 10) < 7;
      out_ready  = ($urandom % 10) < 6;
      flush      = ($urandom % 32) == 0;
      in_inst    = $urandom;
      in_imm_src = 3'($urandom_range(0, 7));
      in_pc      = {$urandom, $urandom};
      in_tag     = 8'($urandom);
    end
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 20 && (qa.size() > 0 || qb.size() > 0); i++) begin
      @(negedge clk); check_cycle();
    end
    chk("drain_pending", 64'(qa.size() + qb.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
